// File: rtl/onchip_ram_param_if.sv
// Avalon-MM slave bus bundle for onchip_ram_param.
// ONCHIP_RAM_PARITY_EN adds the parity_err / inject_parity_err pair.
interface onchip_ram_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic                    clken;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    init_done;
`ifdef ONCHIP_RAM_PARITY_EN
  logic                    parity_err;
  logic                    inject_parity_err;

  modport master (
    output address, byteenable, chipselect, read, write, clken, writedata, inject_parity_err,
    input  readdata, readdatavalid, waitrequest, init_done, parity_err
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, clken, writedata, inject_parity_err,
    output readdata, readdatavalid, waitrequest, init_done, parity_err
  );
`else
  modport master (
    output address, byteenable, chipselect, read, write, clken, writedata,
    input  readdata, readdatavalid, waitrequest, init_done
  );
  modport slave (
    input  address, byteenable, chipselect, read, write, clken, writedata,
    output readdata, readdatavalid, waitrequest, init_done
  );
`endif
endinterface

// File: rtl/onchip_ram_param.sv
// Parameterised on-chip RAM with Avalon-MM slave, optional zero-fill after reset and 1/2-cycle read latency.
// Optional per-lane even parity enabled by defining ONCHIP_RAM_PARITY_EN.
module onchip_ram_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int DEPTH          = 32768,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  onchip_ram_param_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_addr;
  logic             w_wait;
  logic             w_init_done;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_st_vld;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [DATA_WIDTH-1:0] r_rdata_p1;
  logic                  r_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_clr_addr <= '0;
    end else if (bus.clken) begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait      = 1'b1;
    w_init_done = 1'b0;
    case (r_state)
      S_CLEAR: if (r_clr_addr == LAST_IDX) w_state_nxt = S_READY;
      S_READY: begin
        w_wait      = 1'b0;
        w_init_done = 1'b1;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign w_in_range = {1'b0, bus.address} < DEPTH_A;
  assign w_idx      = bus.address[IDX_W-1:0];
  assign w_wr_acc   = (r_state == S_READY) & bus.chipselect & bus.write & bus.clken;
  assign w_rd_acc   = (r_state == S_READY) & bus.chipselect & bus.read & ~bus.write & bus.clken;
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

  // Memory array: zero-fill while clearing, byte-lane writes when ready
  always_ff @(posedge clk) begin
    if (!reset && bus.clken) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_wr_acc && w_in_range) begin
        for (int i = 0; i < NB; i++)
          if (bus.byteenable[i]) r_mem[w_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  function automatic logic [NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_par_wr;
  logic          w_rd_perr;
  logic          w_st_perr;
  logic          r_perr_p1;

  assign w_par_wr  = lane_parity(bus.writedata) ^ NB'(bus.inject_parity_err);
  assign w_rd_perr = w_in_range ? |(r_par[w_idx] ^ lane_parity(r_mem[w_idx])) : 1'b0;

  always_ff @(posedge clk) begin
    if (!reset && bus.clken) begin
      if (r_state == S_CLEAR) begin
        r_par[r_clr_addr] <= '0;
      end else if (w_wr_acc && w_in_range) begin
        for (int i = 0; i < NB; i++)
          if (bus.byteenable[i]) r_par[w_idx][i] <= w_par_wr[i];
      end
    end
  end
`endif

  // Optional extra stage p0 for two-cycle read latency
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_data_p0;
      logic                  r_vld_p0;

      always_ff @(posedge clk) begin
        if (reset)            r_vld_p0 <= 1'b0;
        else if (bus.clken)   r_vld_p0 <= w_rd_acc;
      end

      always_ff @(posedge clk) begin
        if (w_rd_acc) r_data_p0 <= w_rd_data;
      end

      assign w_st_vld  = r_vld_p0;
      assign w_st_data = r_data_p0;
`ifdef ONCHIP_RAM_PARITY_EN
      logic r_perr_p0;
      always_ff @(posedge clk) begin
        if (w_rd_acc) r_perr_p0 <= w_rd_perr;
      end
      assign w_st_perr = r_perr_p0;
`endif
    end else begin : g_lat1
      assign w_st_vld  = w_rd_acc;
      assign w_st_data = w_rd_data;
`ifdef ONCHIP_RAM_PARITY_EN
      assign w_st_perr = w_rd_perr;
`endif
    end
  endgenerate

  // Output stage p1: readdata holds between pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_rdata_p1 <= '0;
    end else if (bus.clken) begin
      r_vld_p1 <= w_st_vld;
      if (w_st_vld) r_rdata_p1 <= w_st_data;
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                        r_perr_p1 <= 1'b0;
    else if (bus.clken && w_st_vld)   r_perr_p1 <= w_st_perr;
    else if (bus.clken)               r_perr_p1 <= 1'b0;
  end
  assign bus.parity_err = r_perr_p1 & r_vld_p1 & bus.clken;
`endif

  // A held pulse stays hidden while clken is low and shows once it returns
  assign bus.readdata      = r_rdata_p1;
  assign bus.readdatavalid = r_vld_p1 & bus.clken;
  assign bus.waitrequest   = w_wait;
  assign bus.init_done     = w_init_done;
endmodule

// File: tb/tb_onchip_ram_param.sv
// Directed bench for onchip_ram_param: one clearing latency-1 instance, one non-clearing latency-2 instance.
// Parity steps compile in when ONCHIP_RAM_PARITY_EN is defined.
module tb_onchip_ram_param;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cnt;
  int   bad;

  always #5 clk = ~clk;

  onchip_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  onchip_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  onchip_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  onchip_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
                     .READ_LATENCY(2), .CLEAR_ON_RESET(0))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_a.address = a; bus_a.writedata = d; bus_a.byteenable = be;
    bus_a.chipselect = 1'b1; bus_a.write = 1'b1; bus_a.read = 1'b0;
    tick();
    bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
  endtask

  task automatic rd_a(input logic [AW-1:0] a);
    bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.write = 1'b0;
    tick();
    bus_a.chipselect = 1'b0; bus_a.read = 1'b0;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [31:0] d);
    bus_b.address = a; bus_b.writedata = d; bus_b.byteenable = 4'hF;
    bus_b.chipselect = 1'b1; bus_b.write = 1'b1; bus_b.read = 1'b0;
    tick();
    bus_b.chipselect = 1'b0; bus_b.write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.address = '0; bus_a.byteenable = 4'hF; bus_a.chipselect = 1'b0; bus_a.read = 1'b0;
    bus_a.write = 1'b0; bus_a.clken = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.byteenable = 4'hF; bus_b.chipselect = 1'b0; bus_b.read = 1'b0;
    bus_b.write = 1'b0; bus_b.clken = 1'b1; bus_b.writedata = '0;
`ifdef ONCHIP_RAM_PARITY_EN
    bus_a.inject_parity_err = 1'b0;
    bus_b.inject_parity_err = 1'b0;
`endif
    tick();
    check("rst_a_rdv", bus_a.readdatavalid, 1'b0);
    check("rst_a_rdata", bus_a.readdata, 32'h0);
    check("rst_a_wait", bus_a.waitrequest, 1'b1);
    check("rst_a_init", bus_a.init_done, 1'b0);
    check("rst_b_wait", bus_b.waitrequest, 1'b0);
    check("rst_b_init", bus_b.init_done, 1'b1);
    check("rst_b_rdv", bus_b.readdatavalid, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;

    cnt = 0;
    while (bus_a.waitrequest && cnt < 40) begin cnt++; tick(); end
    check("clear_cycles", cnt, 16);
    check("clear_init_done", bus_a.init_done, 1'b1);

    for (int i = 0; i < DEP; i++) begin
      rd_a(AW'(i));
      check("clr_rd_vld", bus_a.readdatavalid, 1'b1);
      check("clr_rd_data", bus_a.readdata, 32'h0);
    end
    tick();
    check("idle_no_vld", bus_a.readdatavalid, 1'b0);

    wr_a(5'd5, 32'hDEADBEEF, 4'b0101);
    rd_a(5'd5);
    check("be_partial5", bus_a.readdata, 32'h00AD00EF);
    wr_a(5'd5, 32'hFFFFFFFF, 4'b1111);
    rd_a(5'd5);
    check("be_full5", bus_a.readdata, 32'hFFFFFFFF);
    wr_a(5'd6, 32'hDEADBEEF, 4'b0101);
    rd_a(5'd6);
    check("be_partial6", bus_a.readdata, 32'h00AD00EF);
    tick();
    check("hold_vld", bus_a.readdatavalid, 1'b0);
    check("hold_data", bus_a.readdata, 32'h00AD00EF);

    bus_a.address = 5'd7; bus_a.writedata = 32'h12345678; bus_a.byteenable = 4'hF;
    bus_a.chipselect = 1'b1; bus_a.read = 1'b1; bus_a.write = 1'b1;
    tick();
    bus_a.chipselect = 1'b0; bus_a.read = 1'b0; bus_a.write = 1'b0;
    check("rw_no_vld", bus_a.readdatavalid, 1'b0);
    rd_a(5'd7);
    check("rw_write_done", bus_a.readdata, 32'h12345678);

    wr_a(5'd16, 32'hA5A5A5A5, 4'hF);
    rd_a(5'd0);
    check("oor_no_alias", bus_a.readdata, 32'h0);
    rd_a(5'd16);
    check("oor_rd_vld", bus_a.readdatavalid, 1'b1);
    check("oor_rd_data", bus_a.readdata, 32'h0);

    wr_a(5'd9, 32'hCAFEF00D, 4'hF);
    rd_a(5'd9);
    bus_a.clken = 1'b0;
    bus_a.address = 5'd9; bus_a.writedata = 32'h0; bus_a.chipselect = 1'b1; bus_a.write = 1'b1;
    #1;
    check("clken_lo_vld0", bus_a.readdatavalid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("clken_lo_vld", bus_a.readdatavalid, 1'b0);
    end
    bus_a.chipselect = 1'b0; bus_a.write = 1'b0;
    bus_a.clken = 1'b1;
    #1;
    check("clken_back_vld", bus_a.readdatavalid, 1'b1);
    check("clken_back_data", bus_a.readdata, 32'hCAFEF00D);
    tick();
    check("clken_single_pulse", bus_a.readdatavalid, 1'b0);
    rd_a(5'd9);
    check("clken_no_write", bus_a.readdata, 32'hCAFEF00D);

    wr_b(5'd0, 32'h11111111);
    wr_b(5'd1, 32'h22222222);
    wr_b(5'd2, 32'h33333333);
    bus_b.chipselect = 1'b1; bus_b.read = 1'b1; bus_b.address = 5'd0;
    tick();
    check("lat2_n1_vld", bus_b.readdatavalid, 1'b0);
    bus_b.address = 5'd1;
    tick();
    check("lat2_n2_vld", bus_b.readdatavalid, 1'b1);
    check("lat2_n2_data", bus_b.readdata, 32'h11111111);
    bus_b.address = 5'd2;
    tick();
    bus_b.chipselect = 1'b0; bus_b.read = 1'b0;
    check("lat2_n3_vld", bus_b.readdatavalid, 1'b1);
    check("lat2_n3_data", bus_b.readdata, 32'h22222222);
    tick();
    check("lat2_n4_vld", bus_b.readdatavalid, 1'b1);
    check("lat2_n4_data", bus_b.readdata, 32'h33333333);
    tick();
    check("lat2_n5_vld", bus_b.readdatavalid, 1'b0);

    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("mid_clear_wait", bus_a.waitrequest, 1'b1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("rerst_wait", bus_a.waitrequest, 1'b1);
    check("rerst_init", bus_a.init_done, 1'b0);
    bus_a.address = 5'd2; bus_a.chipselect = 1'b1; bus_a.read = 1'b1;
    cnt = 0; bad = 0;
    while (bus_a.waitrequest && cnt < 40) begin
      if (bus_a.readdatavalid) bad++;
      cnt++;
      tick();
    end
    bus_a.chipselect = 1'b0; bus_a.read = 1'b0;
    check("reclear_cycles", cnt, 16);
    check("reclear_ignored_rd", bad, 0);
    rd_a(5'd9);
    check("reclear_data", bus_a.readdata, 32'h0);
    rd_a(5'd16);
    check("reclear_oor_vld", bus_a.readdatavalid, 1'b1);
    check("reclear_oor_data", bus_a.readdata, 32'h0);
    tick();
    check("reclear_oor_pulse", bus_a.readdatavalid, 1'b0);

`ifdef ONCHIP_RAM_PARITY_EN
    bus_a.inject_parity_err = 1'b1;
    wr_a(5'd3, 32'h01020304, 4'hF);
    bus_a.inject_parity_err = 1'b0;
    rd_a(5'd3);
    check("par_inj_vld", bus_a.readdatavalid, 1'b1);
    check("par_inj_err", bus_a.parity_err, 1'b1);
    wr_a(5'd3, 32'h01020304, 4'hF);
    rd_a(5'd3);
    check("par_ok_vld", bus_a.readdatavalid, 1'b1);
    check("par_ok_err", bus_a.parity_err, 1'b0);
    rd_a(5'd4);
    check("par_clear_err", bus_a.parity_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
